// File: rtl/fft_pkg.sv
// Shared types and size defaults for the FFT output reorder block.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int MAX_R_DEF = 256;
    localparam int MAX_C_DEF = 243;
    localparam int ADDR_W    = $clog2(MAX_R_DEF * MAX_C_DEF);

endpackage

// File: rtl/reorder_ram.sv
// Simple dual-port frame store: one write port, one registered read port (1 cycle).
// Read data holds while re is low, so the reader can stall it in place.
module reorder_ram
    import fft_pkg::*;
#(
    parameter int DW    = 36,
    parameter int DEPTH = MAX_R_DEF * MAX_C_DEF,
    parameter int AW    = ADDR_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft_out_reorder.sv
// Transposes an R x C frame (written row-major, read column-major); first output 2 cycles after last input.
// Input accepted only in FILL; output is a RAM stage plus output register that stall in place on out_ready low.
module fft_out_reorder
    import fft_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int MAX_R = MAX_R_DEF,
    parameter int MAX_C = MAX_C_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [8:0]              pow2,
    input  logic [7:0]              pow3x5,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_re,
    output logic signed [WIDTH-1:0] out_im,
    output logic                    out_last,
    output logic                    busy,
    output logic                    err
);

    localparam int DEPTH = MAX_R * MAX_C;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [8:0] R_LIM = 9'(MAX_R);
    localparam logic [7:0] C_LIM = 8'(MAX_C);

    state_t             state;
    logic [8:0]         rows, wr_r, rd_r;
    logic [7:0]         cols, wr_c, rd_c;
    logic [AW-1:0]      wr_addr, rd_addr;
    logic               rd_done, s1_vld, s1_last;
    logic [2*WIDTH-1:0] rd_dat;

    logic size_ok, wr_fire, wr_end, out_fire, load_out, rd_en, rd_row_end, rd_end;

    assign size_ok    = (pow2 != 9'd0) && (pow2 <= R_LIM) && (pow3x5 != 8'd0) && (pow3x5 <= C_LIM);
    assign wr_fire    = in_valid && in_ready;
    assign wr_end     = (wr_r == rows - 9'd1) && (wr_c == cols - 8'd1);
    assign out_fire   = out_valid && out_ready;
    // The output register takes a new sample when empty or being drained this cycle.
    assign load_out   = s1_vld && (!out_valid || out_ready);
    assign rd_en      = (state == DRAIN) && !rd_done && (!s1_vld || load_out);
    assign rd_row_end = (rd_r == rows - 9'd1);
    assign rd_end     = rd_row_end && (rd_c == cols - 8'd1);

    reorder_ram #(
        .DW    (2 * WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_fire),
        .waddr (wr_addr),
        .wdata ({in_re, in_im}),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_dat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rows      <= '0;
            cols      <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            wr_addr   <= '0;
            wr_r      <= '0;
            wr_c      <= '0;
            rd_addr   <= '0;
            rd_r      <= '0;
            rd_c      <= '0;
            rd_done   <= 1'b0;
            s1_vld    <= 1'b0;
            s1_last   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (size_ok) begin
                            rows     <= pow2;
                            cols     <= pow3x5;
                            wr_addr  <= '0;
                            wr_r     <= '0;
                            wr_c     <= '0;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                            state    <= FILL;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (start) begin
                        err <= 1'b1;
                    end
                    if (wr_fire) begin
                        wr_addr <= wr_addr + 1'b1;
                        if (wr_c == cols - 8'd1) begin
                            wr_c <= '0;
                            wr_r <= wr_r + 9'd1;
                        end else begin
                            wr_c <= wr_c + 8'd1;
                        end
                        if (wr_end) begin
                            in_ready <= 1'b0;
                            rd_addr  <= '0;
                            rd_r     <= '0;
                            rd_c     <= '0;
                            rd_done  <= 1'b0;
                            state    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (start) begin
                        err <= 1'b1;
                    end
                    if (out_fire && out_last) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Column-major walk: step down a column by +C, wrap to the top of the next column.
            if (rd_en) begin
                s1_last <= rd_end;
                if (rd_end) begin
                    rd_done <= 1'b1;
                end else if (rd_row_end) begin
                    rd_r    <= '0;
                    rd_c    <= rd_c + 8'd1;
                    rd_addr <= AW'(rd_c) + 1'b1;
                end else begin
                    rd_r    <= rd_r + 9'd1;
                    rd_addr <= rd_addr + AW'(cols);
                end
            end

            if (rd_en) begin
                s1_vld <= 1'b1;
            end else if (load_out) begin
                s1_vld <= 1'b0;
            end

            if (load_out) begin
                out_valid <= 1'b1;
                out_last  <= s1_last;
                out_re    <= rd_dat[2*WIDTH-1:WIDTH];
                out_im    <= rd_dat[WIDTH-1:0];
            end else if (out_fire) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed and randomized frames against a transpose model built from nested row/column loops.
module tb_fft_out_reorder;

    localparam int W   = 18;
    localparam int LIM = 40000;

    logic         clk;
    logic         rst;
    logic         start;
    logic [8:0]   pow2;
    logic [7:0]   pow3x5;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_re, in_im;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_re, out_im;
    logic         out_last;
    logic         busy;
    logic         err;

    int total = 0;
    int bad   = 0;

    fft_out_reorder #(
        .WIDTH (W),
        .MAX_R (256),
        .MAX_C (243)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pow2      (pow2),
        .pow3x5    (pow3x5),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_last  (out_last),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic bad_start(input logic [8:0] r, input logic [7:0] c);
        do_reset();
        @(negedge clk);
        start = 1'b1; pow2 = r; pow3x5 = c;
        @(negedge clk);
        start = 1'b0;
        check("bad_start_err", err, 1);
        check("bad_start_busy", busy, 0);
        check("bad_start_in_ready", in_ready, 0);
    endtask

    // One full frame: start, fill, drain, compare against the transposed input.
    task automatic run_frame(input int R, input int C, input bit rnd, input int stall,
                             input bit poke_mid, input bit poke_end, input bit seq_data);
        int N, n, k, cyc, since, first, stall_left;
        bit xfer, poked, p_hold, p_last;
        logic [W-1:0] p_re, p_im;
        logic [W-1:0] dre[], dim[];
        logic [W-1:0] exp_re[$], exp_im[$];

        N = R * C;
        dre = new[N];
        dim = new[N];
        for (int i = 0; i < N; i++) begin
            dre[i] = seq_data ? W'(i) : W'($urandom);
            dim[i] = seq_data ? W'(N - 1 - i) : W'($urandom);
        end
        // Sample n carries element (n / C, n % C); output walks rows fastest.
        for (int c = 0; c < C; c++) begin
            for (int r = 0; r < R; r++) begin
                exp_re.push_back(dre[r * C + c]);
                exp_im.push_back(dim[r * C + c]);
            end
        end

        @(negedge clk);
        start = 1'b1; pow2 = 9'(R); pow3x5 = 8'(C);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);

        n = 0; cyc = 0; poked = 0;
        while (n < N && cyc < LIM) begin
            if (poked) begin
                check("busy_after_bad_start", busy, 1);
                poked = 0;
            end
            in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_re = dre[n];
            in_im = dim[n];
            start = poke_mid && (n == 1);
            if (start) begin
                pow2 = 9'd8; pow3x5 = 8'd8; poked = 1;
            end
            xfer = in_valid && in_ready;
            @(negedge clk);
            cyc++;
            if (xfer) n++;
        end
        start = 1'b0;
        check("fill_count", n, N);

        k = 0; cyc = 0; since = 1; first = 0; stall_left = stall; p_hold = 0;
        p_re = '0; p_im = '0; p_last = 0;
        check("in_ready_low_in_drain", in_ready, 0);
        while (k < N && cyc < LIM) begin
            if (p_hold) begin
                check("stall_valid", out_valid, 1);
                check("stall_re", out_re, p_re);
                check("stall_im", out_im, p_im);
                check("stall_last", out_last, p_last);
            end
            if (out_valid && first == 0) begin
                first = since;
                check("first_valid_latency", since, 3);
            end
            if (!rnd && stall == 0 && first != 0) begin
                check("no_bubble", out_valid, 1);
            end
            if (first != 0 && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            in_valid = 1'($urandom_range(0, 1));
            in_re = W'($urandom);
            in_im = W'($urandom);
            start = poke_end && out_valid && out_ready && (k == N - 1);
            if (start) begin
                pow2 = 9'd4; pow3x5 = 8'd3;
            end
            if (out_valid && out_ready) begin
                check("out_re", out_re, exp_re[k]);
                check("out_im", out_im, exp_im[k]);
                check("out_last", out_last, (k == N - 1));
                k++;
            end
            p_hold = out_valid && !out_ready;
            p_re = out_re; p_im = out_im; p_last = out_last;
            @(negedge clk);
            since++;
            cyc++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("drain_count", k, N);
        check("idle_busy", busy, 0);
        check("idle_out_valid", out_valid, 0);
    endtask

    initial begin
        int cnt, cyc;
        bit xfer;
        rst = 1'b1; start = 1'b0; pow2 = '0; pow3x5 = '0;
        in_valid = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_re", out_re, 0);
        check("rst_out_im", out_im, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        rst = 1'b0;

        run_frame(4, 3, 0, 0, 0, 0, 1);
        run_frame(1, 5, 0, 0, 0, 0, 0);
        run_frame(8, 1, 1, 0, 0, 0, 0);
        run_frame(2, 2, 0, 10, 0, 0, 0);
        run_frame(8, 4, 1, 10, 0, 0, 0);
        run_frame(16, 27, 1, 0, 0, 0, 0);
        run_frame(256, 9, 1, 0, 0, 0, 0);
        run_frame(2, 243, 1, 0, 0, 0, 0);
        run_frame(32, 81, 1, 0, 0, 0, 0);
        check("err_clean_after_good_frames", err, 0);

        bad_start(9'd0, 8'd3);
        bad_start(9'd4, 8'd0);
        bad_start(9'd257, 8'd3);
        bad_start(9'd4, 8'd244);

        do_reset();
        check("err_cleared_by_rst", err, 0);
        run_frame(2, 2, 0, 0, 1, 0, 1);
        check("err_start_in_fill", err, 1);

        do_reset();
        run_frame(4, 3, 1, 0, 0, 1, 0);
        check("err_start_at_drain_end", err, 1);

        do_reset();
        @(negedge clk);
        start = 1'b1; pow2 = 9'd4; pow3x5 = 8'd3;
        @(negedge clk);
        start = 1'b0;
        cnt = 0; cyc = 0;
        while (cnt < 5 && cyc < 100) begin
            in_valid = 1'b1;
            in_re = W'(100 + cnt);
            in_im = W'(200 + cnt);
            xfer = in_ready;
            @(negedge clk);
            cyc++;
            if (xfer) cnt++;
        end
        in_valid = 1'b0;
        check("partial_fill_count", cnt, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midfill_rst_busy", busy, 0);
        check("midfill_rst_in_ready", in_ready, 0);
        check("midfill_rst_err", err, 0);
        check("midfill_rst_out_valid", out_valid, 0);
        run_frame(2, 2, 0, 0, 0, 0, 1);
        check("err_after_clean_frame", err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
